spike_event_packer: RTL

//   Downstream of the two IN_V2_Char neurons (positive and inverted ECG channels).

---
 rtl/ecg_spike_pkg.sv | 30 +++
 rtl/spike_fifo.sv | 64 ++++++
 rtl/spike_event_packer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ecg_spike_pkg.sv
// ============================================================================
// Package     : ecg_spike_pkg
// Description : Shared channel codes, default field widths and small helpers
//               for the ECG spike event path (packer and classifier).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecg_spike_pkg;

  // Default dt field width and resulting event width {chan, dt}
  localparam int TS_W_DEF = 12;
  localparam int EV_W_DEF = TS_W_DEF + 2;

  // Channel code carried in the top two bits of every event
  typedef enum logic [1:0] {
    CH_NONE = 2'b00,
    CH_POS  = 2'b01,
    CH_NEG  = 2'b10,
    CH_BOTH = 2'b11
  } chan_t;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_fifo.sv
// ============================================================================
// Module      : spike_fifo
// Description : Synchronous FIFO with extra-MSB pointers. Push and pop in the
//               same cycle both succeed when full; pop while empty is ignored.
//               Head data is read from the registered storage array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_fifo
  import ecg_spike_pkg::*;
#(
  parameter int WIDTH = EV_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO may still accept
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; reset also clears storage so the head reads 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_event_packer.sv
// ============================================================================
// Module      : spike_event_packer
// Description : Turns rising edges on the positive / inverted ECG neuron spike
//               lines into {chan, dt} events, queues them in spike_fifo and
//               drains them over a valid/ready port. Sticky overflow flag.
//               Optional per-window spike rate counters are built only when
//               the macro SPIKE_RATE_EN is defined; otherwise the rate
//               outputs are constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_event_packer
  import ecg_spike_pkg::*;
#(
  parameter int TS_W    = TS_W_DEF,
  parameter int DEPTH   = 8,
  parameter int WIN_LEN = 360
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spike_pos,
  input  logic            spike_neg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TS_W+1:0] out_event,
  output logic            overflow,
  output logic [7:0]      rate_pos,
  output logic [7:0]      rate_neg,
  output logic            rate_valid
);

  // Elaboration-time parameter sanity
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("spike_event_packer: DEPTH must be a power of 2 and >= 2");
  end
  if (WIN_LEN < 2) begin : g_bad_win
    $error("spike_event_packer: WIN_LEN must be >= 2");
  end

  logic            pos_q;
  logic            neg_q;
  logic            edge_pos;
  logic            edge_neg;
  logic            ev;
  chan_t           chan;
  logic [TS_W-1:0] dt_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            accept;

  // A level held high produces exactly one edge
  assign edge_pos = spike_pos & ~pos_q;
  assign edge_neg = spike_neg & ~neg_q;
  assign ev       = edge_pos | edge_neg;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  // Mirrors the FIFO's own acceptance rule so dt and overflow track real writes
  assign accept    = ev & (~fifo_full | pop);

  // Channel encode; simultaneous edges merge into a single CH_BOTH event
  always_comb begin
    chan = CH_NONE;
    if (edge_pos && edge_neg) begin
      chan = CH_BOTH;
    end else if (edge_pos) begin
      chan = CH_POS;
    end else if (edge_neg) begin
      chan = CH_NEG;
    end
  end

  // Previous-cycle spike levels for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      pos_q <= spike_pos;
      neg_q <= spike_neg;
    end
  end

  // Cycles since the last stored event; saturates, restarts only on a real write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dt_cnt <= '0;
    end else if (accept) begin
      dt_cnt <= TS_W'(1);
    end else if (dt_cnt != {TS_W{1'b1}}) begin
      dt_cnt <= dt_cnt + TS_W'(1);
    end
  end

  // Sticky drop indicator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ev && !accept) begin
      overflow <= 1'b1;
    end
  end

  spike_fifo #(
    .WIDTH (TS_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev),
    .pop   (pop),
    .din   ({chan, dt_cnt}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (out_event)
  );

`ifdef SPIKE_RATE_EN
  localparam int WIN_W = $clog2(WIN_LEN);

  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       cnt_pos;
  logic [7:0]       cnt_neg;
  logic [7:0]       cnt_pos_nxt;
  logic [7:0]       cnt_neg_nxt;
  logic             win_end;

  assign win_end     = (win_cnt == WIN_W'(WIN_LEN - 1));
  // Edges are counted at detection, whether or not the FIFO took them
  assign cnt_pos_nxt = sat_inc8(cnt_pos, edge_pos);
  assign cnt_neg_nxt = sat_inc8(cnt_neg, edge_neg);

  // Window and per-channel counters; results and strobe register together at
  // the edge closing the last window cycle, so rate_valid and the new rates
  // appear in the same (following) cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      cnt_pos    <= '0;
      cnt_neg    <= '0;
      rate_pos   <= '0;
      rate_neg   <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= win_end;
      if (win_end) begin
        win_cnt  <= '0;
        cnt_pos  <= '0;
        cnt_neg  <= '0;
        rate_pos <= cnt_pos_nxt;
        rate_neg <= cnt_neg_nxt;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        cnt_pos <= cnt_pos_nxt;
        cnt_neg <= cnt_neg_nxt;
      end
    end
  end
`else
  assign rate_pos   = 8'd0;
  assign rate_neg   = 8'd0;
  assign rate_valid = 1'b0;
`endif

endmodule

`default_nettype wire
